fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the RISC-V core. It owns the PC and issues in-order word requests to instruction memory over a valid/ready handshake. It tracks in-flight requests and buffers returned instruction words with their PCs in a small FIFO. It presents them to decode (control unit and immediate generator), and handles branch/jump redirects by discarding stale responses.

## Interface
- RESET_PC, 32'h0000_0000, PC of first fetch after reset
- DEPTH, 2, FIFO entries and maximum outstanding-plus-buffered instructions (power of 2, ≥2)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, ≥1 cycle after acceptance, cannot be stalled
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 00
- dec_valid  out  1  dec_inst/dec_pc valid
- dec_ready  in  1  decode consumes this cycle
- dec_inst  out  32  instruction word to decode
- dec_pc  out  32  PC of dec_inst

## Operation
- Counters: out_cnt (accepted requests not yet responded, 0..DEPTH), fifo_cnt (0..DEPTH), drop_cnt (responses to discard, 0..DEPTH).
- FSM states: BOOT, FETCH, FLUSH.
  - BOOT: entered on reset; no requests; next cycle → FETCH.
  - FETCH: imem_req_valid = out_cnt + fifo_cnt − pop < DEPTH, where pop = dec_valid & dec_ready in the same cycle.
    - On req fire (valid & ready): pc += 4.
    - On imem_rsp_valid: push {pc_of_rsp, data}. pc_of_rsp comes from an internal in-order PC queue, or equivalently from fetched-address tracking.
  - On redirect_valid in FETCH: pc ← {redirect_pc[31:2],2'b00}; FIFO cleared; drop_cnt ← out_cnt + req_fire − rsp_fire (a response arriving in the redirect cycle is dropped, not pushed). If that value is 0, stay in FETCH; else → FLUSH.
  - FLUSH: imem_req_valid = 0; each imem_rsp_valid decrements drop_cnt and is not pushed. When drop_cnt reaches 0 → FETCH.
  - Redirect in FLUSH: pc updated, FIFO stays empty, drop_cnt unchanged (still equals out_cnt).
- Request stability: once imem_req_valid is high, it and imem_req_addr are held until accepted. The only exception is redirect, which may change the address or drop valid.
- Priority: reset > redirect > push/pop. Simultaneous push and pop keep fifo_cnt unchanged.
- dec_valid = (fifo_cnt ≠ 0) & ~redirect_valid & (state ≠ FLUSH). dec_inst/dec_pc come from the FIFO head. Output data is held stable while dec_valid & ~dec_ready.
- The credit rule guarantees the FIFO never overflows. An overflow or underflow condition is a design error; the bench flags it with an assertion.
- PC wrap: 32'hFFFF_FFFC + 4 → 32'h0000_0000.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=0, state=BOOT, all counters 0.
- Reset high mid-operation (any state) returns all state to reset values next edge. Responses to pre-reset requests are outside this block's contract; the memory is reset together with it.
- First request: second cycle after reset deasserts (BOOT then FETCH), address RESET_PC.
- Fetch-to-decode latency: response cycle + 1 (registered FIFO). dec_valid is never combinational from imem_rsp_valid.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory latency, imem_req_ready=1, dec_ready=1, DEPTH=2.
- Redirect takes effect on the next edge. With out_cnt=0 and no in-flight acceptance, the first request to the new PC appears the cycle after redirect.
- imem_req_valid and dec_valid depend combinationally on redirect_valid, dec_ready and state only. They never depend on imem_rsp_*.

## Test plan
- Reset/boot: RESET_PC=32'h100, hold reset 3 cycles, then release → cycle 2 after release imem_req_valid=1, addr=0x100. Outputs match reset values while reset is high.
- Streaming: 1-cycle memory returning addr as data, ready=1, dec_ready=1 → dec_pc 0x100,0x104,0x108,… on consecutive cycles, dec_inst==dec_pc, no bubbles after fill.
- Decode backpressure: dec_ready=0 for 5 cycles mid-stream → at most DEPTH entries buffered, out_cnt+fifo_cnt ≤ 2. Requests stop, no word lost or duplicated, order resumes exactly when dec_ready=1.
- Redirect with in-flight requests: 3-cycle memory latency, redirect_pc=0x2002 with out_cnt=2 → FLUSH entered, 2 responses dropped, dec_valid=0 throughout. The next request is addr 0x2000, and the first dec_pc is 0x2000.
- Redirect edge cases: redirect with out_cnt=0 → stays in FETCH, next request is the new PC. Redirect coincident with rsp_valid and req fire → both counted in drop_cnt. A second redirect in FLUSH to 0x3000 → the first post-flush request is 0x3000.
- Reset during FLUSH and PC wrap: assert reset with drop_cnt=2 → next cycle state=BOOT, all counters 0. Redirect to 0xFFFF_FFFC → the following fetch is 0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC owner, credit-limited requests, response FIFO, redirect flush
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] fifo_cnt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] out_next;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic          pop;
   logic          push;
   logic          req_fire;
   logic [CW:0]   credit_used;
   logic [CW:0]   credit_limit;
   logic [31:0]   target;

   assign target        = {redirect_pc[31:2], 2'b00};
   assign dec_valid     = (fifo_cnt != '0) && !redirect_valid && (state != FLUSH);
   assign pop           = dec_valid && dec_ready;
   // A slot freed by decode this cycle can be re-requested in the same cycle.
   assign credit_used   = {1'b0, out_cnt} + {1'b0, fifo_cnt};
   assign credit_limit  = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
   assign imem_req_valid = (state == FETCH) && (credit_used < credit_limit);
   assign req_fire      = imem_req_valid && imem_req_ready;
   assign push          = (state == FETCH) && imem_rsp_valid && !redirect_valid;
   assign out_next      = out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
   assign imem_req_addr = pc;
   assign dec_inst      = inst_mem[rd_ptr];
   assign dec_pc        = pc_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         rsp_pc   <= RESET_PC;
         out_cnt  <= '0;
         fifo_cnt <= '0;
         drop_cnt <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else begin
         out_cnt <= out_next;
         case (state)
            BOOT: state <= FETCH;
            FETCH: begin
               if (redirect_valid) begin
                  // Everything still in flight, including this cycle's acceptance, is stale.
                  pc       <= target;
                  rsp_pc   <= target;
                  fifo_cnt <= '0;
                  rd_ptr   <= '0;
                  wr_ptr   <= '0;
                  drop_cnt <= out_next;
                  state    <= (out_next == '0) ? FETCH : FLUSH;
               end else begin
                  if (req_fire) pc <= pc + 32'd4;
                  if (push) begin
                     pc_mem[wr_ptr]   <= rsp_pc;
                     inst_mem[wr_ptr] <= imem_rsp_data;
                     wr_ptr           <= wr_ptr + AW'(1);
                     rsp_pc           <= rsp_pc + 32'd4;
                  end
                  if (pop) rd_ptr <= rd_ptr + AW'(1);
                  fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
               end
            end
            FLUSH: begin
               if (redirect_valid) begin
                  pc     <= target;
                  rsp_pc <= target;
               end
               if (imem_rsp_valid) begin
                  drop_cnt <= drop_cnt - CW'(1);
                  if (drop_cnt == CW'(1)) state <= FETCH;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed bench for fetch_ctrl against a queue-based fetch model
module tb_fetch_ctrl;
   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          DEPTH = 2;
   localparam logic [31:0] KEY   = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;

   fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lat = 1;
   int last_due = 0;
   bit prev_reset = 1'b0;
   int          mem_due[$];
   logic [31:0] mem_addr[$];
   // Model: in-flight PCs, buffered entries, and count of responses still to be discarded.
   bit          m_boot = 1'b1;
   logic [31:0] m_pc = RPC;
   logic [31:0] m_infl[$];
   int          m_drop = 0;
   logic [31:0] m_fpc[$];
   logic [31:0] m_finst[$];
   logic        s_req_valid, s_dec_valid;
   logic [31:0] s_addr;
   logic [31:0] req_log[$];
   logic [31:0] dec_log[$];
   int          dec_cyc[$];

   always @(negedge clk)
      if (!reset) assert (dut.fifo_cnt <= DEPTH && dut.out_cnt <= DEPTH)
         else $error("FAIL fifo_bounds: fifo_cnt=%0d out_cnt=%0d limit %0d", dut.fifo_cnt, dut.out_cnt, DEPTH);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s cycle %0d: condition not reached within bound", name, cyc);
   endtask

   task automatic tick();
      bit e_req, e_dec, pop, fire, rsp, redir;
      int due;
      logic [31:0] rdata, rpc_ent, rtgt;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (reset) begin
         mem_due.delete(); mem_addr.delete(); last_due = 0;
      end else if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_addr[0] ^ KEY;
         void'(mem_due.pop_front());
         void'(mem_addr.pop_front());
      end
      #1;
      e_dec = (m_fpc.size() > 0) && !redirect_valid && (m_drop == 0);
      pop   = e_dec && dec_ready;
      e_req = !m_boot && (m_drop == 0) && (m_infl.size() + m_fpc.size() - int'(pop) < DEPTH);
      s_req_valid = imem_req_valid; s_addr = imem_req_addr; s_dec_valid = dec_valid;
      if (reset) begin
         if (prev_reset) begin
            chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
            chk("reset_req_addr", imem_req_addr, RPC);
            chk("reset_dec_valid", 32'(dec_valid), 32'd0);
            chk("reset_dec_inst", dec_inst, 32'd0);
            chk("reset_dec_pc", dec_pc, 32'd0);
         end
      end else begin
         chk("req_valid", 32'(imem_req_valid), 32'(e_req));
         if (e_req) chk("req_addr", imem_req_addr, m_pc);
         chk("dec_valid", 32'(dec_valid), 32'(e_dec));
         if (e_dec) begin
            chk("dec_pc", dec_pc, m_fpc[0]);
            chk("dec_inst", dec_inst, m_finst[0]);
         end
         if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mem_due.push_back(due); mem_addr.push_back(imem_req_addr); last_due = due;
         end
         if (dec_valid && dec_ready) begin
            dec_log.push_back(dec_pc); dec_cyc.push_back(cyc);
         end
      end
      fire = e_req && imem_req_ready;
      rsp = imem_rsp_valid; rdata = imem_rsp_data;
      redir = redirect_valid; rtgt = {redirect_pc[31:2], 2'b00};
      @(posedge clk);
      if (reset) begin
         m_boot = 1'b1; m_pc = RPC; m_infl.delete(); m_drop = 0; m_fpc.delete(); m_finst.delete();
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else begin
         rpc_ent = '0;
         if (rsp && m_infl.size() > 0) rpc_ent = m_infl.pop_front();
         if (fire) m_infl.push_back(m_pc);
         if (redir) begin
            m_pc = rtgt; m_fpc.delete(); m_finst.delete();
            if (m_drop > 0) begin
               if (rsp) m_drop--;
            end else m_drop = m_infl.size();
         end else begin
            if (fire) m_pc += 32'd4;
            if (m_drop > 0) begin
               if (rsp) m_drop--;
            end else begin
               if (pop) begin void'(m_fpc.pop_front()); void'(m_finst.pop_front()); end
               if (rsp) begin m_fpc.push_back(rpc_ent); m_finst.push_back(rdata); end
            end
         end
      end
      prev_reset = reset;
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Waits for a given in-flight count (and buffered count unless negative), optionally with no response due now.
   task automatic wait_for(input int ni, input int nf, input bit no_rsp, input string name);
      int k = 0;
      while (!(m_infl.size() == ni && (nf < 0 || m_fpc.size() == nf) &&
               !(no_rsp && mem_due.size() > 0 && mem_due[0] <= cyc)) && k < 50) begin
         tick(); k++;
      end
      if (k >= 50) timeout(name);
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1; redirect_pc = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic expect_first(input string name, input logic [31:0] q[$], input int mark, input logic [31:0] exp);
      if (q.size() > mark) chk(name, q[mark], exp);
      else timeout(name);
   endtask

   initial begin
      int mark, dmark, k;
      // Reset and boot
      run(3);
      reset = 1'b0;
      tick(); chk("boot_req_valid", 32'(s_req_valid), 32'd0);
      imem_req_ready = 1'b1; dec_ready = 1'b1; lat = 1;
      tick(); chk("first_req_valid", 32'(s_req_valid), 32'd1); chk("first_req_addr", s_addr, 32'h100);
      // Streaming, then decode backpressure
      run(20);
      for (int i = 0; i < 8; i++) begin
         if (dec_log.size() > i + 1) begin
            chk("stream_pc", dec_log[i], 32'h100 + 32'(4 * i));
            chk("stream_no_bubble", 32'(dec_cyc[i+1] - dec_cyc[i]), 32'd1);
         end else timeout("stream_pc");
      end
      dec_ready = 1'b0;
      run(5);
      chk("stall_req_valid", 32'(s_req_valid), 32'd0);
      chk("stall_dec_valid", 32'(s_dec_valid), 32'd1);
      dec_ready = 1'b1;
      run(10);
      for (int i = 0; i < dec_log.size(); i++) chk("stream_order", dec_log[i], 32'h100 + 32'(4 * i));
      // Redirect with two requests in flight, then a second redirect during the flush
      for (int pass = 0; pass < 2; pass++) begin
         lat = 3;
         wait_for(2, -1, 1'b1, "wait_inflight2");
         mark = req_log.size(); dmark = dec_log.size();
         redirect_to(32'h2002);
         if (pass == 1) redirect_to(32'h3000);
         k = 0;
         while (m_drop > 0 && k < 20) begin
            tick(); k++;
            chk("flush_dec_valid", 32'(s_dec_valid), 32'd0);
            chk("flush_req_valid", 32'(s_req_valid), 32'd0);
         end
         run(12);
         expect_first("redirect_req", req_log, mark, pass == 0 ? 32'h2000 : 32'h3000);
         expect_first("redirect_dec", dec_log, dmark, pass == 0 ? 32'h2000 : 32'h3000);
      end
      // Redirect with nothing in flight, then a redirect coinciding with a response and a request
      lat = 1; dec_ready = 1'b0;
      wait_for(0, DEPTH, 1'b0, "wait_idle_full");
      mark = req_log.size();
      redirect_to(32'h500);
      dec_ready = 1'b1;
      tick(); chk("idle_redirect_valid", 32'(s_req_valid), 32'd1); chk("idle_redirect_addr", s_addr, 32'h500);
      redirect_to(32'h700);
      tick(); chk("coincident_flush_req", 32'(s_req_valid), 32'd0); chk("coincident_flush_dec", 32'(s_dec_valid), 32'd0);
      run(6);
      expect_first("coincident_stale_req", req_log, mark + 1, 32'h504);
      expect_first("coincident_new_req", req_log, mark + 2, 32'h700);
      // Reset while flushing
      lat = 3;
      wait_for(2, -1, 1'b1, "wait_inflight2b");
      redirect_to(32'h4000);
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      tick(); chk("rst_boot_req_valid", 32'(s_req_valid), 32'd0);
      tick(); chk("rst_first_req", s_addr, 32'h100); chk("rst_first_valid", 32'(s_req_valid), 32'd1);
      // PC wrap
      lat = 1; dec_ready = 1'b0;
      wait_for(0, DEPTH, 1'b0, "wait_idle_full2");
      mark = req_log.size();
      redirect_to(32'hFFFF_FFFE);
      dec_ready = 1'b1;
      run(4);
      expect_first("wrap_req0", req_log, mark, 32'hFFFF_FFFC);
      expect_first("wrap_req1", req_log, mark + 1, 32'h0000_0000);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) lat = $urandom_range(1, 3);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         dec_ready      = ($urandom_range(0, 3) != 0);
         reset          = ($urandom_range(0, 299) == 0);
         redirect_valid = !redirect_valid && !reset && !m_boot && ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom;
         tick();
      end
      reset = 1'b0; redirect_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
